// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, NOP word, fetch FSM state encoding and jump decode helper
package mips_pkg;
    localparam logic [5:0] OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_HOLD = 2'd2;
    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction
endpackage

// File: rtl/instruction_fetch_mips_if.sv
// instruction_fetch_mips_if: PC, instruction memory and decoder signals of the fetch stage
interface instruction_fetch_mips_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] ptr;
    logic [DATA_W-1:0] mem_addr;
    logic mem_req;
    logic mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instruction;
    logic instr_valid;
    logic decode_ready;
    logic pc_en;
    logic is_jump;
    logic fetch_err;
    modport master (
        input ptr, mem_ack, mem_rdata, decode_ready,
        output mem_addr, mem_req, instruction, instr_valid, pc_en, is_jump, fetch_err
    );
    modport slave (
        output ptr, mem_ack, mem_rdata, decode_ready,
        input mem_addr, mem_req, instruction, instr_valid, pc_en, is_jump, fetch_err
    );
endinterface

// File: rtl/instruction_fetch_mips_timeout.sv
// fetch_timeout_counter: counts memory wait cycles, flags expiry at TIMEOUT-1
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16,
    localparam int CW = $clog2(TIMEOUT) + 1
) (
    input logic clk,
    input logic reset,
    input logic clear,
    input logic enable,
    output logic expired
);
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        expired = count_q == CW'(TIMEOUT - 1);
        count_d = clear ? '0 : ((enable && !expired) ? count_q + 1'b1 : count_q);
    end
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/instruction_fetch_mips.sv
// instruction_fetch_mips: req/ack instruction fetch with timeout NOP and valid/ready hold
module instruction_fetch_mips
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 16,
    parameter logic [DATA_W-1:0] NOP = NOP_WORD
) (
    input logic clk,
    input logic reset,
    instruction_fetch_mips_if.master bus
);
    state_t state_q, state_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d, instruction_q, instruction_d;
    logic mem_req_q, mem_req_d, instr_valid_q, instr_valid_d;
    logic pc_en_q, pc_en_d, is_jump_q, is_jump_d, fetch_err_q, fetch_err_d;
    logic cnt_clear, cnt_enable, cnt_expired;
    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk),
        .reset(reset),
        .clear(cnt_clear),
        .enable(cnt_enable),
        .expired(cnt_expired)
    );
    always_comb begin
        state_d = state_q;
        mem_addr_d = mem_addr_q;
        mem_req_d = mem_req_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        pc_en_d = 1'b0;
        is_jump_d = 1'b0;
        fetch_err_d = fetch_err_q;
        cnt_clear = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_addr_d = {bus.ptr[DATA_W-1:2], 2'b00};
                mem_req_d = 1'b1;
                cnt_clear = 1'b1;
                fetch_err_d = fetch_err_q | (bus.ptr[1:0] != 2'b00);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ack takes priority over a coincident timeout
                if (bus.mem_ack || cnt_expired) begin
                    instruction_d = bus.mem_ack ? bus.mem_rdata : NOP;
                    fetch_err_d = fetch_err_q | !bus.mem_ack;
                    mem_req_d = 1'b0;
                    instr_valid_d = 1'b1;
                    state_d = S_HOLD;
                end else cnt_enable = 1'b1;
            end
            S_HOLD: begin
                if (instr_valid_q && bus.decode_ready) begin
                    instr_valid_d = 1'b0;
                    pc_en_d = 1'b1;
                    is_jump_d = is_jump_op(instruction_q[DATA_W-1 -: 6]);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mem_addr_q <= '0;
            mem_req_q <= 1'b0;
            instruction_q <= NOP;
            instr_valid_q <= 1'b0;
            pc_en_q <= 1'b0;
            is_jump_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q <= mem_req_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            pc_en_q <= pc_en_d;
            is_jump_q <= is_jump_d;
            fetch_err_q <= fetch_err_d;
        end
    end
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_req = mem_req_q;
    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_en = pc_en_q;
    assign bus.is_jump = is_jump_q;
    assign bus.fetch_err = fetch_err_q;
endmodule

// File: tb/tb_instruction_fetch_mips.sv
// tb_instruction_fetch_mips: directed self-checking bench for the fetch stage
module tb_instruction_fetch_mips;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    instruction_fetch_mips_if #(.DATA_W(32)) bus ();
    instruction_fetch_mips #(.DATA_W(32), .TIMEOUT(16), .NOP(32'h0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.ptr = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.decode_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction got %h want 0", bus.instruction); end
        checks++; if ({bus.instr_valid, bus.pc_en, bus.is_jump, bus.fetch_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {bus.instr_valid, bus.pc_en, bus.is_jump, bus.fetch_err}); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        do_reset();
        bus.ptr = 32'h4;
        bus.decode_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL fetch_req got req=%0b addr=%h want req=1 addr=4", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_wait got valid=%0b req=%0b want 0 1", bus.instr_valid, bus.mem_req); end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h2008_0005;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instruction !== 32'h2008_0005 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_valid got valid=%0b instr=%h req=%0b want 1 20080005 0", bus.instr_valid, bus.instruction, bus.mem_req); end
        @(negedge clk);
        bus.ptr = 32'h8;
        checks++; if (bus.pc_en !== 1'b1 || bus.is_jump !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got pc_en=%0b jump=%0b valid=%0b want 1 0 0", bus.pc_en, bus.is_jump, bus.instr_valid); end
        @(negedge clk);
        checks++; if (bus.pc_en !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin errors++; $display("FAIL fetch_next got pc_en=%0b req=%0b addr=%h want 0 1 8", bus.pc_en, bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_jump();
        do_reset();
        bus.ptr = 32'h10;
        bus.decode_ready = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0800_0010;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instruction !== 32'h0800_0010) begin errors++; $display("FAIL jump_instr got %h want 08000010", bus.instruction); end
        @(negedge clk);
        checks++; if (bus.pc_en !== 1'b1 || bus.is_jump !== 1'b1) begin errors++; $display("FAIL jump_pulse got pc_en=%0b jump=%0b want 1 1", bus.pc_en, bus.is_jump); end
        @(negedge clk);
        checks++; if (bus.pc_en !== 1'b0 || bus.is_jump !== 1'b0) begin errors++; $display("FAIL jump_clear got pc_en=%0b jump=%0b want 0 0", bus.pc_en, bus.is_jump); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        bus.ptr = 32'h10;
        bus.decode_ready = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.fetch_err !== 1'b0 || bus.instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_pre got err=%0b instr=%h want 0 deadbeef", bus.fetch_err, bus.instruction); end
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_req !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d want 16", n); end
        checks++; if (bus.instruction !== 32'h0 || bus.instr_valid !== 1'b1 || bus.fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_nop got instr=%h valid=%0b err=%0b want 0 1 1", bus.instruction, bus.instr_valid, bus.fetch_err); end
        repeat (2) @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instruction !== 32'h1234_5678 || bus.fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got instr=%h err=%0b want 12345678 1", bus.instruction, bus.fetch_err); end
    endtask

    task automatic test_hold_stall();
        int pulses = 0;
        do_reset();
        bus.ptr = 32'h20;
        bus.decode_ready = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h8C01_0004;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.instruction !== 32'h8C01_0004 || bus.instr_valid !== 1'b1 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got instr=%h valid=%0b pc_en=%0b want 8c010004 1 0", i, bus.instruction, bus.instr_valid, bus.pc_en); end
        end
        bus.decode_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulses += int'(bus.pc_en);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int jumps = 0;
        do_reset();
        bus.ptr = 32'h40;
        bus.decode_ready = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0C00_0020;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pulses += int'(bus.pc_en);
            jumps += int'(bus.pc_en & bus.is_jump);
        end
        bus.mem_ack = 1'b0;
        checks++; if (pulses < 2 || jumps !== pulses) begin errors++; $display("FAIL b2b_jal got pc_en=%0d jal=%0d want >=2 and equal", pulses, jumps); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ptr = 32'h30;
        bus.decode_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin errors++; $display("FAIL mid_wait got req=%0b err=%0b want 1 0", bus.mem_req, bus.fetch_err); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req got %0b want 0", bus.mem_req); end
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        bus.ptr = 32'h6;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0) begin errors++; $display("FAIL mid_late_ack got valid=%0b instr=%h want 0 0", bus.instr_valid, bus.instruction); end
        checks++; if (bus.mem_addr !== 32'h4 || bus.fetch_err !== 1'b1 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_misalign got addr=%h err=%0b req=%0b want 4 1 1", bus.mem_addr, bus.fetch_err, bus.mem_req); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_jump();
        test_timeout();
        test_hold_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
